// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - stream, control and status bundle for seq_det_ctrl
// master drives config/control/stream; slave is the detector side.
interface seq_det_ctrl_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             cfg_we;
   logic [PAT_W-1:0] cfg_pattern;
   logic [CNT_W-1:0] cfg_win;
   logic [CNT_W-1:0] cfg_limit;
   logic             start;
   logic             abort;
   logic             din;
   logic             din_valid;
   logic             done_ack;
   logic             busy;
   logic             match;
   logic [CNT_W-1:0] match_cnt;
   logic             done;
   logic [1:0]       stop_code;
   logic             cfg_err;

   modport master (
      output cfg_we, cfg_pattern, cfg_win, cfg_limit, start, abort,
             din, din_valid, done_ack,
      input  busy, match, match_cnt, done, stop_code, cfg_err
   );

   modport slave (
      input  cfg_we, cfg_pattern, cfg_win, cfg_limit, start, abort,
             din, din_valid, done_ack,
      output busy, match, match_cnt, done, stop_code, cfg_err
   );
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - bounded serial pattern detection run controller
// Optional SEQ_DET_NOOVERLAP_EN: a match restarts the fill so matches cannot overlap.
module seq_det_ctrl #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst,
   seq_det_ctrl_if.slave bus
);
   localparam int FW = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [PAT_W-1:0] pattern_q, hist_q, hist_nxt;
   logic [CNT_W-1:0] win_q, limit_q;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_nxt, match_cnt_q, match_cnt_nxt;
   logic [FW-1:0]    fill_q, fill_nxt;
   logic [1:0]       stop_q, stop_nxt;
   logic             hit;
   logic             match_q, busy_q, done_q, cfg_err_q;

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      hist_nxt      = hist_q;
      fill_nxt      = fill_q;
      bit_cnt_nxt   = bit_cnt_q;
      match_cnt_nxt = match_cnt_q;
      stop_nxt      = stop_q;
      hit           = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               state_nxt     = S_RUN;
               hist_nxt      = '0;
               fill_nxt      = '0;
               bit_cnt_nxt   = '0;
               match_cnt_nxt = '0;
               stop_nxt      = 2'b00;
            end
         end
         S_RUN: begin
            // Abort wins outright; the bit offered in that cycle is dropped.
            if (bus.abort) begin
               stop_nxt  = 2'b11;
               state_nxt = S_DONE;
            end else if (bus.din_valid) begin
               hist_nxt    = {hist_q[PAT_W-2:0], bus.din};
               fill_nxt    = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
               bit_cnt_nxt = bit_cnt_q + 1'b1;
               hit         = (hist_nxt == pattern_q) && (fill_nxt == FW'(PAT_W));
               if (hit && (match_cnt_q != '1)) match_cnt_nxt = match_cnt_q + 1'b1;
`ifdef SEQ_DET_NOOVERLAP_EN
               if (hit) fill_nxt = '0;
`endif
               if ((limit_q != '0) && (match_cnt_nxt == limit_q)) begin
                  stop_nxt  = 2'b10;
                  state_nxt = S_DONE;
               end else if ((win_q != '0) && (bit_cnt_nxt == win_q)) begin
                  stop_nxt  = 2'b01;
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (bus.done_ack) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pattern_q   <= '0;
         win_q       <= '0;
         limit_q     <= '0;
         hist_q      <= '0;
         fill_q      <= '0;
         bit_cnt_q   <= '0;
         match_cnt_q <= '0;
         stop_q      <= 2'b00;
         match_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         hist_q      <= hist_nxt;
         fill_q      <= fill_nxt;
         bit_cnt_q   <= bit_cnt_nxt;
         match_cnt_q <= match_cnt_nxt;
         stop_q      <= stop_nxt;
         match_q     <= hit;
         busy_q      <= (state_nxt == S_RUN);
         done_q      <= (state_nxt == S_DONE);
         cfg_err_q   <= bus.cfg_we && (state != S_IDLE);
         if ((state == S_IDLE) && bus.cfg_we) begin
            pattern_q <= bus.cfg_pattern;
            win_q     <= bus.cfg_win;
            limit_q   <= bus.cfg_limit;
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.match     = match_q;
   assign bus.match_cnt = match_cnt_q;
   assign bus.done      = done_q;
   assign bus.stop_code = stop_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed and random checks of seq_det_ctrl against a bit-history model
module tb_seq_det_ctrl;
   localparam int PAT_W = 4;
   localparam int CNT_W = 8;
   localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef SEQ_DET_NOOVERLAP_EN
   localparam bit NOOV = 1'b1;
`else
   localparam bit NOOV = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   seq_det_ctrl_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus ();

   seq_det_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks = 0;
   int errors = 0;

   // Model: phase 0 idle, 1 running, 2 finished; bits accepted this run kept in a queue.
   int phase, m_pat, m_win, m_lim, nbits, since, mcnt, scode;
   bit e_match, e_cfg_err;
   bit m_hist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_tick();
      int val;
      e_match   = 1'b0;
      e_cfg_err = 1'b0;
      if (!rst) begin
         phase = 0; m_pat = 0; m_win = 0; m_lim = 0;
         nbits = 0; since = 0; mcnt = 0; scode = 0;
         m_hist.delete();
         return;
      end
      e_cfg_err = bus.cfg_we && (phase != 0);
      if (phase == 0) begin
         if (bus.cfg_we) begin
            m_pat = int'(bus.cfg_pattern);
            m_win = int'(bus.cfg_win);
            m_lim = int'(bus.cfg_limit);
         end
         if (bus.start) begin
            phase = 1; nbits = 0; since = 0; mcnt = 0; scode = 0;
            m_hist.delete();
         end
      end else if (phase == 1) begin
         if (bus.abort) begin
            scode = 3;
            phase = 2;
         end else if (bus.din_valid) begin
            m_hist.push_back(bus.din);
            if (m_hist.size() > PAT_W) void'(m_hist.pop_front());
            nbits++;
            since++;
            val = 0;
            foreach (m_hist[i]) val = (val << 1) | int'(m_hist[i]);
            if (since >= PAT_W && val == m_pat) begin
               e_match = 1'b1;
               if (mcnt < MAXC) mcnt++;
               if (NOOV) since = 0;
            end
            if (m_lim != 0 && mcnt == m_lim) scode = 2;
            else if (m_win != 0 && (nbits & MAXC) == m_win) scode = 1;
            if (scode != 0) phase = 2;
         end
      end else if (phase == 2) begin
         if (bus.done_ack) phase = 0;
      end
   endtask

   task automatic step();
      model_tick();
      @(posedge clk);
      #1;
      chk("match", bus.match, e_match);
      chk("match_cnt", bus.match_cnt, mcnt);
      chk("busy", bus.busy, phase == 1);
      chk("done", bus.done, phase == 2);
      chk("stop_code", bus.stop_code, scode);
      chk("cfg_err", bus.cfg_err, e_cfg_err);
   endtask

   task automatic clr_in();
      bus.cfg_we = 0; bus.cfg_pattern = '0; bus.cfg_win = '0; bus.cfg_limit = '0;
      bus.start = 0; bus.abort = 0; bus.din = 0; bus.din_valid = 0; bus.done_ack = 0;
   endtask

   task automatic bitin(input logic b);
      bus.din = b; bus.din_valid = 1'b1;
      step();
      bus.din = 1'b0; bus.din_valid = 1'b0;
   endtask

   task automatic run_cfg(input int pat, input int win, input int lim);
      bus.cfg_we = 1'b1; bus.start = 1'b1;
      bus.cfg_pattern = PAT_W'(pat); bus.cfg_win = CNT_W'(win); bus.cfg_limit = CNT_W'(lim);
      step();
      bus.cfg_we = 1'b0; bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1; step(); bus.abort = 1'b0;
   endtask

   task automatic pulse_ack();
      bus.done_ack = 1'b1; step(); bus.done_ack = 1'b0;
   endtask

   initial begin
      clr_in();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
      chk("rst_match_cnt", bus.match_cnt, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_stop", bus.stop_code, 0);

      // Overlapping detection of 1011 in 1011011.
      run_cfg(4'b1011, 0, 0);
      bitin(1); bitin(0); bitin(1); bitin(1);
      chk("ovl_first", bus.match, 1);
      bitin(0); bitin(1); bitin(1);
      chk("ovl_second", bus.match, NOOV ? 0 : 1);
      bus.din = 1'b1; bus.din_valid = 1'b1;
      pulse_abort();
      bus.din = 1'b0; bus.din_valid = 1'b0;
      chk("ovl_stop", bus.stop_code, 3);
      chk("ovl_cnt", bus.match_cnt, NOOV ? 1 : 2);
      chk("ovl_abort_bit", bus.match, 0);
      pulse_ack();
      chk("ovl_ack_done", bus.done, 0);

      // Window of 5 with gaps.
      run_cfg(4'b1011, 5, 0);
      bitin(1); step(); bitin(0); bitin(1); step(); bitin(1);
      chk("win_match", bus.match, 1);
      step();
      chk("win_not_done", bus.done, 0);
      bitin(1);
      chk("win_done", bus.done, 1);
      chk("win_busy", bus.busy, 0);
      chk("win_stop", bus.stop_code, 1);
      chk("win_cnt", bus.match_cnt, 1);
      pulse_ack();

      // Limit beats window on the same bit; din in DONE is ignored.
      run_cfg(4'b1011, 4, 1);
      bitin(1); bitin(0); bitin(1); bitin(1);
      chk("tie_stop", bus.stop_code, 2);
      bitin(1); bitin(0); bitin(1); bitin(1);
      chk("tie_cnt", bus.match_cnt, 1);
      chk("tie_done", bus.done, 1);
      pulse_ack();

      // Fill guard: cleared history must not produce early zero matches.
      run_cfg(4'b0000, 6, 0);
      bitin(0); bitin(0); bitin(0);
      chk("fill_early", bus.match, 0);
      bitin(0);
      chk("fill_first", bus.match, 1);
      bitin(0); bitin(0);
      chk("fill_cnt", bus.match_cnt, NOOV ? 1 : 3);
      chk("fill_stop", bus.stop_code, 1);
      pulse_ack();

      // Config write during RUN, ack+start in DONE, later start clears count.
      run_cfg(4'b1011, 0, 0);
      bus.cfg_we = 1'b1; bus.cfg_pattern = '0;
      step();
      bus.cfg_we = 1'b0;
      chk("hs_cfg_err", bus.cfg_err, 1);
      step();
      chk("hs_cfg_err_pulse", bus.cfg_err, 0);
      bitin(1); bitin(0); bitin(1); bitin(1);
      chk("hs_pattern_kept", bus.match, 1);
      pulse_abort();
      bus.start = 1'b1; bus.done_ack = 1'b1;
      step();
      bus.start = 1'b0; bus.done_ack = 1'b0;
      chk("hs_ack_busy", bus.busy, 0);
      chk("hs_ack_done", bus.done, 0);
      step();
      chk("hs_no_run", bus.busy, 0);
      chk("hs_cnt_kept", bus.match_cnt, 1);
      bus.start = 1'b1; step(); bus.start = 1'b0;
      chk("hs_restart_cnt", bus.match_cnt, 0);
      chk("hs_restart_busy", bus.busy, 1);
      pulse_abort();
      pulse_ack();

      // Reset in the middle of a run.
      run_cfg(4'b1011, 0, 0);
      bitin(1); bitin(0); bitin(1); bitin(1); bitin(0); bitin(1); bitin(1);
      rst = 1'b0;
      step();
      rst = 1'b1;
      chk("mrst_cnt", bus.match_cnt, 0);
      chk("mrst_busy", bus.busy, 0);
      chk("mrst_done", bus.done, 0);
      bus.start = 1'b1; step(); bus.start = 1'b0;
      bitin(0); bitin(0); bitin(0); bitin(0);
      chk("mrst_pattern_zero", bus.match, 1);
      pulse_abort();
      pulse_ack();

      // Random traffic checked cycle by cycle against the model.
      for (int n = 0; n < 3000; n++) begin
         rst             = ($urandom_range(0, 199) != 0);
         bus.cfg_we      = ($urandom_range(0, 7) == 0);
         bus.cfg_pattern = PAT_W'($urandom);
         bus.cfg_win     = CNT_W'($urandom_range(0, 20));
         bus.cfg_limit   = CNT_W'($urandom_range(0, 4));
         bus.start       = ($urandom_range(0, 3) == 0);
         bus.abort       = ($urandom_range(0, 29) == 0);
         bus.din         = $urandom_range(0, 1);
         bus.din_valid   = ($urandom_range(0, 2) != 0);
         bus.done_ack    = ($urandom_range(0, 3) == 0);
         step();
      end
      rst = 1'b1;
      clr_in();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
Run controller for serial pattern detection. It holds a programmable PAT_W-bit pattern, runs a bounded detection session on a valid-qualified serial bit stream, counts matches, and stops on window expiry, match limit or abort. A done/ack handshake reports the result to the sequencing logic. It sits between the stream source and the status/CSR logic and is the configurable successor to fixed-pattern detectors.

Parameters:
PAT_W, 4, pattern length in bits (2..16)
CNT_W, 8, width of window length, match limit, bit counter and match counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-low
cfg_we  input  1  config write strobe; honoured only in IDLE
cfg_pattern  input  PAT_W  pattern; MSB is the oldest bit
cfg_win  input  CNT_W  bits to observe per run; 0 = unbounded
cfg_limit  input  CNT_W  match count that ends a run; 0 = unbounded
start  input  1  begin a run; honoured only in IDLE
abort  input  1  terminate the run; honoured only in RUN
din  input  1  serial data bit
din_valid  input  1  din qualifier
done_ack  input  1  acknowledge done; honoured only in DONE
busy  output  1  high while in RUN
match  output  1  1-cycle pulse per detected match
match_cnt  output  CNT_W  matches in current/last run, saturating
done  output  1  high in DONE until acknowledged
stop_code  output  2  01 window, 10 limit, 11 abort, 00 none
cfg_err  output  1  1-cycle pulse when cfg_we is seen outside IDLE

Behaviour:
- Reset (rst=0 at clk edge): state IDLE; pattern/win/limit regs = 0; busy, match, done, cfg_err = 0; match_cnt = 0; stop_code = 00; history and counters cleared. All outputs are registered.
- FSM states: IDLE, RUN, DONE. Encoding is free; all other codes go to IDLE.
- IDLE: cfg_we loads the config registers. start moves to RUN, clears history, fill counter, bit counter, match_cnt and stop_code. If cfg_we and start occur together, the run uses the newly written values.
- RUN: each edge with din_valid=1 shifts din into hist (hist <= {hist[PAT_W-2:0], din}), increments bit_cnt and increments fill (saturates at PAT_W). din_valid=0 leaves everything unchanged.
- Match: on an accepted bit, if the new hist equals pattern and the new fill equals PAT_W, match=1 in the following cycle and match_cnt increments, saturating at 2^CNT_W-1. Latency is 1 cycle from the accepted bit. Overlapping matches count by default.
- Stop conditions are evaluated on each accepted bit using the updated counts. Priority is abort > limit > window.
- Limit: cfg_limit != 0 and the new match_cnt == cfg_limit gives stop_code 10.
- Window: cfg_win != 0 and the new bit_cnt == cfg_win gives stop_code 01.
- Abort in RUN gives stop_code 11 on the next edge. A bit presented in the abort cycle is discarded and produces no match.
- Any stop moves RUN to DONE. busy falls and done rises in the same cycle. din is ignored in DONE and IDLE.
- DONE: done held high, and match_cnt and stop_code stay frozen until done_ack. done_ack moves to IDLE and done=0 next cycle. start in the same cycle as done_ack is ignored. match_cnt and stop_code persist in IDLE until the next start.
- start outside IDLE, abort outside RUN and done_ack outside DONE are ignored. cfg_we outside IDLE leaves the config unchanged and pulses cfg_err.
- With cfg_win=0 and cfg_limit=0, only abort ends a run.

Optional Feature:
SEQ_DET_NOOVERLAP_EN. When defined, a match clears fill to 0, so the next match needs PAT_W fresh accepted bits (non-overlapping detection). When undefined, overlapping detection applies as above.

Test Plan:
- Overlap: pattern=1011, win=0, limit=0, stream 1,0,1,1,0,1,1 then abort. Required: match pulses after bit 4 and bit 7, match_cnt=2, stop_code=11. With SEQ_DET_NOOVERLAP_EN, only one pulse and match_cnt=1.
- Window: pattern=1011, win=5, stream 1,0,1,1,1 with din_valid gaps. Required: match after bit 4, done the cycle after bit 5, stop_code=01, match_cnt=1, busy=0.
- Limit vs window tie: pattern=1011, win=4, limit=1, stream 1,0,1,1. Required: stop_code=10, match_cnt=1, and extra din in DONE leaves match_cnt unchanged.
- Fill guard: pattern=0000, win=6, stream of six 0s right after start. Required: first match after bit 4, then bits 5 and 6 match, match_cnt=3. Stale zeros in hist must not match early.
- Handshake/config: cfg_we during RUN gives one cfg_err pulse and pattern unchanged. done_ack with start in DONE gives IDLE and no new run. A later start clears match_cnt to 0.
- Reset mid-run: rst=0 in RUN after 2 matches. Required: next cycle IDLE, match_cnt=0, done=0, busy=0, pattern reg=0.
